// File: rtl/gh_pkg.sv
// Shared types and default constants for the greenhouse temperature display.
package gh_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        PEND_ON  = 2'd1,
        ALERT    = 2'd2,
        PEND_OFF = 2'd3
    } alert_state_t;

    typedef enum logic [1:0] {
        S_OK   = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } sample_class_t;

    localparam int DEF_T_MIN = 18;
    localparam int DEF_BAR_W = 8;

endpackage

// File: rtl/therm_encode.sv
// Combinational rounding of the averaged temperature, clamping to the display
// window, thermometer coding and LOW/OK/HIGH classification.
module therm_encode
    import gh_pkg::*;
#(
    parameter int TEMP_W = 16,
    parameter int NR_W   = 8,
    parameter int BAR_W  = DEF_BAR_W,
    parameter int T_MIN  = DEF_T_MIN
) (
    input  logic [TEMP_W-1:0] temp_q_i,
    input  logic [TEMP_W-1:0] temp_r_i,
    input  logic [NR_W-1:0]   nr_i,
    output logic [BAR_W-1:0]  code_o,
    output sample_class_t     cls_o
);

    localparam logic [TEMP_W-1:0] TMIN_C = TEMP_W'(T_MIN);
    localparam logic [TEMP_W-1:0] TMAX_C = TEMP_W'(T_MIN + BAR_W);

    logic [TEMP_W+1:0] twice_r;
    logic [TEMP_W+1:0] nr_ext;
    logic              round_up;
    logic [TEMP_W:0]   sum;
    logic [TEMP_W-1:0] t_rnd;
    logic [TEMP_W-1:0] bars;

    // 2*R is compared at TEMP_W+2 bits so it can never wrap against N.
    assign twice_r  = {1'b0, temp_r_i, 1'b0};
    assign nr_ext   = (TEMP_W+2)'(nr_i);
    assign round_up = (twice_r >= nr_ext);
    assign sum      = {1'b0, temp_q_i} + (TEMP_W+1)'(round_up);
    assign t_rnd    = sum[TEMP_W] ? {TEMP_W{1'b1}} : sum[TEMP_W-1:0];
    assign bars     = t_rnd - TMIN_C;

    always_comb begin
        code_o = '0;
        cls_o  = S_OK;
        if (t_rnd < TMIN_C) begin
            code_o = BAR_W'(1);
            cls_o  = S_LOW;
        end else if (t_rnd > TMAX_C) begin
            code_o = {BAR_W{1'b1}};
            cls_o  = S_HIGH;
        end else begin
            code_o = ~({BAR_W{1'b1}} << bars);
            cls_o  = S_OK;
        end
    end

endmodule

// File: rtl/display_alert_ctrl.sv
// Registers the thermometer code of each averaged sample and runs the
// debounced, direction-aware over/under-temperature alert FSM.
module display_alert_ctrl
    import gh_pkg::*;
#(
    parameter int TEMP_W = 16,
    parameter int NR_W   = 8,
    parameter int BAR_W  = DEF_BAR_W,
    parameter int T_MIN  = DEF_T_MIN,
    parameter int DEB_N  = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [TEMP_W-1:0] temp_Q_i,
    input  logic [TEMP_W-1:0] temp_R_i,
    input  logic [NR_W-1:0]   active_sensors_nr_i,
    output logic [BAR_W-1:0]  coded_out_o,
    output logic              out_valid_o,
    output logic              alert_o,
    output logic              alert_hi_o,
    output logic              fault_o
);

    localparam int                CNT_W = $clog2(DEB_N + 1);
    localparam logic [CNT_W-1:0]  DEB_C = CNT_W'(DEB_N);

    logic [BAR_W-1:0] code_d;
    sample_class_t    cls_d;
    logic             is_hi;
    logic             nr_zero;

    alert_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dir_q;
    logic [BAR_W-1:0] coded_q;
    logic             out_valid_q;
    logic             alert_q;
    logic             alert_hi_q;
    logic             fault_q;

    therm_encode #(
        .TEMP_W (TEMP_W),
        .NR_W   (NR_W),
        .BAR_W  (BAR_W),
        .T_MIN  (T_MIN)
    ) u_enc (
        .temp_q_i (temp_Q_i),
        .temp_r_i (temp_R_i),
        .nr_i     (active_sensors_nr_i),
        .code_o   (code_d),
        .cls_o    (cls_d)
    );

    assign is_hi   = (cls_d == S_HIGH);
    assign nr_zero = (active_sensors_nr_i == '0);
    // Saturating increment: the count never needs to exceed DEB_N.
    assign cnt_d   = (cnt_q >= DEB_C) ? DEB_C : cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= NORMAL;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            coded_q     <= '0;
            out_valid_q <= 1'b0;
            alert_q     <= 1'b0;
            alert_hi_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (valid_i && nr_zero) begin
                fault_q <= 1'b1;
            end else if (valid_i) begin
                coded_q     <= code_d;
                out_valid_q <= 1'b1;
                case (state_q)
                    NORMAL: begin
                        if (cls_d == S_OK) begin
                            cnt_q <= '0;
                        end else if (DEB_N == 1) begin
                            state_q    <= ALERT;
                            cnt_q      <= '0;
                            dir_q      <= is_hi;
                            alert_q    <= 1'b1;
                            alert_hi_q <= is_hi;
                        end else begin
                            state_q <= PEND_ON;
                            cnt_q   <= CNT_W'(1);
                            dir_q   <= is_hi;
                        end
                    end
                    PEND_ON: begin
                        if (cls_d == S_OK) begin
                            state_q <= NORMAL;
                            cnt_q   <= '0;
                        end else if (is_hi != dir_q) begin
                            cnt_q <= CNT_W'(1);
                            dir_q <= is_hi;
                        end else if (cnt_d >= DEB_C) begin
                            state_q    <= ALERT;
                            cnt_q      <= '0;
                            alert_q    <= 1'b1;
                            alert_hi_q <= dir_q;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    ALERT: begin
                        if (cls_d != S_OK) begin
                            dir_q      <= is_hi;
                            alert_hi_q <= is_hi;
                        end else if (DEB_N == 1) begin
                            state_q <= NORMAL;
                            cnt_q   <= '0;
                            alert_q <= 1'b0;
                        end else begin
                            state_q <= PEND_OFF;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    PEND_OFF: begin
                        if (cls_d != S_OK) begin
                            state_q    <= ALERT;
                            cnt_q      <= '0;
                            dir_q      <= is_hi;
                            alert_hi_q <= is_hi;
                        end else if (cnt_d >= DEB_C) begin
                            state_q <= NORMAL;
                            cnt_q   <= '0;
                            alert_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: begin
                        state_q <= NORMAL;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign coded_out_o = coded_q;
    assign out_valid_o = out_valid_q;
    assign alert_o     = alert_q;
    assign alert_hi_o  = alert_hi_q;
    assign fault_o     = fault_q;

endmodule
